// File: rtl/mips_loader_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mips_loader_pkg : shared constants and state encoding for the IMEM loader |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
package mips_loader_pkg;

  localparam int CNT_W  = 16;
  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    ST_CNT_HI = 3'd0,
    ST_CNT_LO = 3'd1,
    ST_DATA   = 3'd2,
    ST_CSUM   = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERR    = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/byte_word_assembler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | byte_word_assembler : packs MSB-first bytes into 32-bit words             |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module byte_word_assembler
  import mips_loader_pkg::*;
(
  input  logic              clk,
  input  logic              i_clear,
  input  logic              i_en,
  input  logic [BYTE_W-1:0] i_byte,
  output logic              o_last_byte,
  output logic              o_word_valid,
  output logic [WORD_W-1:0] o_word
);

  localparam int SHIFT_W = WORD_W - BYTE_W;

  logic [SHIFT_W-1:0] r_shift;
  logic [1:0]         r_cnt;
  logic               r_word_valid;
  logic [WORD_W-1:0]  r_word;

  // The finished word is captured separately so it stays stable while the
  // next word's first byte shifts in during the write pulse.
  always_ff @(posedge clk) begin
    if (i_clear) begin
      r_shift      <= '0;
      r_cnt        <= 2'd0;
      r_word_valid <= 1'b0;
      r_word       <= '0;
    end else begin
      r_word_valid <= 1'b0;
      if (i_en) begin
        r_shift <= {r_shift[SHIFT_W-BYTE_W-1:0], i_byte};
        r_cnt   <= r_cnt + 2'd1;
        if (r_cnt == 2'd3) begin
          r_word_valid <= 1'b1;
          r_word       <= {r_shift, i_byte};
        end
      end
    end
  end

  assign o_last_byte  = (r_cnt == 2'd3);
  assign o_word_valid = r_word_valid;
  assign o_word       = r_word;

endmodule
`default_nettype wire

// File: rtl/imem_program_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | imem_program_loader : byte-stream image loader for the instruction ROM    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module imem_program_loader
  import mips_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = CNT_W
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  reload,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_hold,
  output logic                  load_done,
  output logic                  load_err,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam logic [31:0] c_depth = 32'd1 << ADDR_WIDTH;

  state_t                r_state;
  logic [BYTE_W-1:0]     r_cnt_hi;
  logic [BYTE_W-1:0]     r_sum;
  logic [CNT_WIDTH-1:0]  r_n;
  logic                  r_ready;
  logic                  r_hold;
  logic                  r_done;
  logic                  r_err;
  logic [ADDR_WIDTH:0]   r_words;
  logic [ADDR_WIDTH-1:0] r_addr;

  logic                  w_clear;
  logic                  w_accept;
  logic                  w_data_byte;
  logic                  w_last_byte;
  logic                  w_last_word;
  logic                  w_n_over;
  logic [CNT_WIDTH-1:0]  w_n;
  logic                  w_word_valid;
  logic [WORD_W-1:0]     w_word;

  assign w_clear     = RST | reload;
  assign w_accept    = in_valid & r_ready;
  assign w_data_byte = w_accept && (r_state == ST_DATA);
  assign w_n         = {r_cnt_hi, in_data};
  assign w_n_over    = 32'(w_n) > c_depth;
  assign w_last_word = (32'(r_words) + 32'd1) == 32'(r_n);

  byte_word_assembler u_asm (
    .clk          (CLK),
    .i_clear      (w_clear),
    .i_en         (w_data_byte),
    .i_byte       (in_data),
    .o_last_byte  (w_last_byte),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  always_ff @(posedge CLK) begin
    if (w_clear) begin
      r_state  <= ST_CNT_HI;
      r_cnt_hi <= '0;
      r_sum    <= '0;
      r_n      <= '0;
      r_ready  <= 1'b1;
      r_hold   <= 1'b1;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_words  <= '0;
      r_addr   <= '0;
    end else begin
      case (r_state)
        ST_CNT_HI: begin
          if (w_accept) begin
            r_cnt_hi <= in_data;
            r_state  <= ST_CNT_LO;
          end
        end
        ST_CNT_LO: begin
          if (w_accept) begin
            r_n <= w_n;
            if (w_n_over) begin
              r_state <= ST_ERR;
              r_err   <= 1'b1;
              r_ready <= 1'b0;
            end else if (w_n == '0) begin
              r_state <= ST_CSUM;
            end else begin
              r_state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (w_accept) begin
            r_sum <= r_sum + in_data;
            // Address is the pre-increment count; the write pulse follows next cycle.
            if (w_last_byte) begin
              r_addr  <= r_words[ADDR_WIDTH-1:0];
              r_words <= r_words + (ADDR_WIDTH+1)'(1);
              if (w_last_word) begin
                r_state <= ST_CSUM;
              end
            end
          end
        end
        ST_CSUM: begin
          if (w_accept) begin
            r_ready <= 1'b0;
            if (in_data == r_sum) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_hold  <= 1'b0;
            end else begin
              r_state <= ST_ERR;
              r_err   <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready     = r_ready;
  assign imem_we      = w_word_valid;
  assign imem_addr    = r_addr;
  assign imem_wdata   = w_word;
  assign core_hold    = r_hold;
  assign load_done    = r_done;
  assign load_err     = r_err;
  assign words_loaded = r_words;

endmodule
`default_nettype wire

// File: doc/imem_program_loader.md
Name: imem_program_loader

Overview:
Upstream feeder for the MIPS core's instruction memory. It receives a program image as a byte stream, assembles 32-bit big-endian instruction words, and writes them into the instruction ROM write port. It holds the core in reset until the image is loaded and its checksum is verified. This replaces load-by-simulation-file with a synthesizable load path.

Parameters:
ADDR_WIDTH, 8, word-address width of the instruction memory; depth = 2**ADDR_WIDTH words.
CNT_WIDTH, 16, width of the word-count header field; fixed at 16.

Ports:
CLK  input  1  system clock.
RST  input  1  reset; one clock, synchronous, active-high.
reload  input  1  one-cycle pulse; restarts a load from any state.
in_valid  input  1  byte-stream valid.
in_data  input  8  byte-stream data.
in_ready  output  1  loader accepts a byte this cycle when in_valid && in_ready.
imem_we  output  1  instruction-memory write enable, one-cycle pulse per word.
imem_addr  output  ADDR_WIDTH  word address of the write.
imem_wdata  output  32  instruction word.
core_hold  output  1  high holds the core in reset; low lets it run.
load_done  output  1  image loaded and checksum good (sticky).
load_err  output  1  overflow or checksum mismatch (sticky).
words_loaded  output  ADDR_WIDTH+1  count of words written so far.

Behaviour:
- Stream format, in order: count_hi, count_lo (N = 16-bit word count), then 4N data bytes with the MSB first for each word, then one checksum byte. The checksum is the mod-256 sum of all 4N data bytes. The header bytes are not summed.
- States: CNT_HI -> CNT_LO -> DATA -> CSUM -> DONE | ERR.
- RST or reload (reload has no priority over RST; both give the same result):
  - state = CNT_HI.
  - imem_we = 0, imem_addr = 0, imem_wdata = 0.
  - core_hold = 1, load_done = 0, load_err = 0, words_loaded = 0.
  - byte index = 0, running sum = 0.
- in_ready = 1 in CNT_HI, CNT_LO, DATA and CSUM. in_ready = 0 in DONE and ERR. There is no other backpressure; one byte can be accepted every cycle.
- CNT_HI: on accept, latch the high byte and go to CNT_LO.
- CNT_LO: on accept, form N and apply in this order:
  - if N > 2**ADDR_WIDTH, go to ERR;
  - else if N = 0, go to CSUM;
  - else go to DATA.
- DATA:
  - Each accepted byte shifts into a 32-bit assembly register and is added to the sum.
  - On the 4th byte of a word, in the next cycle: imem_we = 1, imem_wdata = the assembled word, imem_addr = words_loaded (pre-increment value). In the same cycle words_loaded increments.
  - The write pulse can overlap acceptance of the next word's first byte.
  - After the 4th byte of word N-1, go to CSUM.
- CSUM: on accept, compare with the sum. Equal -> DONE, else -> ERR.
- DONE: load_done = 1 and core_hold = 0, registered, one cycle after the checksum byte is accepted. The state is held until RST or reload.
- ERR: load_err = 1 and core_hold stays 1. The state is held until RST or reload.
- in_valid gaps: bytes may arrive with any number of idle cycles between them. The state and partial word are held.
- Reload mid-load: the partial word is discarded and no write is issued for it. Words already written stay in memory, but words_loaded is cleared.
- Address never wraps: N is bounded by the overflow check.

Decomposition:
- Shared package `mips_loader_pkg`:
  - state enum constants;
  - CNT_WIDTH;
  - byte and word widths.
- One sub-module, `byte_word_assembler`: shift register plus 2-bit byte counter. It outputs word_valid and word, and has a clear input driven by RST or reload.
- The FSM, checksum and counters stay in the top loader.

Test Plan:
- Stream 00 02 | 20 08 00 05 | 20 09 00 0C | sum byte 0x62 -> exactly two write pulses: addr 0 = 0x20080005, addr 1 = 0x2009000C. load_done = 1 and core_hold = 0 one cycle after the checksum byte; words_loaded = 2.
- Same stream with checksum 0x63 -> ERR: load_err = 1, core_hold stays 1, in_ready = 0, and both words are still written.
- With ADDR_WIDTH = 8, header 01 01 (N = 257) -> load_err = 1 the cycle after count_lo, with no write pulses. Header 01 00 is accepted.
- Header 00 00 then checksum 00 -> load_done = 1, no writes, words_loaded = 0.
- First test stream with random 0-5 cycle in_valid gaps -> identical writes and the same done timing relative to the last accept.
- After 1.5 words, pulse reload, then send the full first stream -> no write of the partial word, words_loaded restarts at 0, result matches the first test. The same check with RST instead of reload gives the same result.
